// File: rtl/freq_meter_auto.sv
// Self-ranging frequency meter: synchronised rising edges pass through a decade prescaler
// into a saturating BCD counter, which is latched once per gate window with range and overflow.
module freq_meter_auto #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int DIGITS      = 4,
  parameter int MAX_RANGE   = 3,
  localparam int RW         = (MAX_RANGE < 1) ? 1 : $clog2(MAX_RANGE + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                signal,
  input  logic                auto_en,
  input  logic [RW-1:0]       range_sel,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [RW-1:0]       range_now,
  output logic                overflow,
  output logic                valid
);

  localparam int BW = 4 * DIGITS;

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  localparam int PTOP = pow10(MAX_RANGE) - 1;
  localparam int PW   = (PTOP < 2) ? 1 : $clog2(PTOP + 1);
  localparam int GW   = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [RW-1:0] RANGE_MAX = RW'(MAX_RANGE);
  localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'd9}};

  // Terminal prescaler value for range r, i.e. 10^r - 1.
  function automatic logic [PW-1:0] presc_last(input logic [RW-1:0] r);
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i <= MAX_RANGE; i++) v = (r == RW'(i)) ? PW'(pow10(i) - 1) : v;
    return v;
  endfunction

  // Decimal increment with per-digit carry.
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*d +: 4] = v[4*d +: 4];
      end
    end
    return r;
  endfunction

  logic          sync1_r, sync2_r, sync3_r, edge_r;
  logic [GW-1:0] gate_r;
  logic [PW-1:0] presc_r;
  logic [BW-1:0] cnt_r;
  logic          ovf_r;
  logic [RW-1:0] range_r;

  logic          window_end_s;
  logic          presc_wrap_s;
  logic          msd_zero_s;
  logic [RW-1:0] range_clamp_s;
  logic [RW-1:0] range_next_s;

  assign window_end_s  = (gate_r == GATE_LAST);
  assign presc_wrap_s  = (presc_r == presc_last(range_r));
  assign msd_zero_s    = (cnt_r[BW-1 -: 4] == 4'd0);
  assign range_clamp_s = (range_sel > RANGE_MAX) ? RANGE_MAX : range_sel;

  // Range for the next window; a step down only when the count still fits one decade lower.
  always_comb begin
    range_next_s = range_r;
    if (!auto_en) begin
      range_next_s = range_clamp_s;
    end else if (ovf_r && (range_r < RANGE_MAX)) begin
      range_next_s = range_r + RW'(1);
    end else if (!ovf_r && msd_zero_s && (range_r != '0)) begin
      range_next_s = range_r - RW'(1);
    end else begin
      range_next_s = range_r;
    end
  end

  // Two-flop synchroniser plus edge register yielding a one-cycle rising-edge pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= signal;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      edge_r  <= sync2_r & ~sync3_r;
    end
  end

  // Free-running gate timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_r <= '0;
    end else if (window_end_s) begin
      gate_r <= '0;
    end else begin
      gate_r <= gate_r + GW'(1);
    end
  end

  // Prescaler, BCD counter and active range; an edge on the window end opens the new window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= '0;
      cnt_r   <= '0;
      ovf_r   <= 1'b0;
      range_r <= '0;
    end else if (window_end_s) begin
      range_r <= range_next_s;
      ovf_r   <= 1'b0;
      if (edge_r && (range_next_s == '0)) begin
        presc_r <= '0;
        cnt_r   <= BW'(1);
      end else if (edge_r) begin
        presc_r <= PW'(1);
        cnt_r   <= '0;
      end else begin
        presc_r <= '0;
        cnt_r   <= '0;
      end
    end else if (edge_r) begin
      if (presc_wrap_s) begin
        presc_r <= '0;
        if (cnt_r == ALL_NINES) begin
          ovf_r <= 1'b1;
        end else begin
          cnt_r <= bcd_inc(cnt_r);
        end
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Result latch and valid strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_out   <= '0;
      range_now <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= window_end_s;
      if (window_end_s) begin
        bcd_out   <= cnt_r;
        range_now <= range_r;
        overflow  <= ovf_r;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_auto.sv
// Bench for freq_meter_auto: edges are tallied per window with their synchroniser delay,
// and each result is predicted from the count, the decade range and the ranging rules.
module tb_freq_meter_auto;
  localparam int GATE = 1000;
  localparam int DIG  = 2;
  localparam int MAXR = 2;
  localparam int RW   = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             signal;
  logic             auto_en;
  logic [RW-1:0]    range_sel;
  logic [4*DIG-1:0] bcd_out;
  logic [RW-1:0]    range_now;
  logic             overflow;
  logic             valid;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;
  logic prev_sig;
  int   ewin [64];
  int   mrange;
  int   hi_t, lo_t, ph;
  logic [7:0] last_bcd;
  logic [1:0] last_rng;
  logic       last_ovf;

  freq_meter_auto #(.GATE_CYCLES(GATE), .DIGITS(DIG), .MAX_RANGE(MAXR)) dut (
    .clk(clk), .reset_n(reset_n), .signal(signal), .auto_en(auto_en),
    .range_sel(range_sel), .bcd_out(bcd_out), .range_now(range_now),
    .overflow(overflow), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Valid strobe every cycle; at a window end, the predicted result and next range.
  task automatic check_cycle();
    int   w, e, dv, cp, cnt;
    logic exp_v;
    exp_v = ((cyc % GATE) == 0);
    check("valid", {31'd0, valid}, {31'd0, exp_v});
    if (exp_v) begin
      w  = cyc / GATE - 1;
      e  = ewin[w];
      dv = 1;
      for (int i = 0; i < mrange; i++) dv = dv * 10;
      cp  = e / dv;
      cnt = (cp > 99) ? 99 : cp;
      check("bcd_out", {24'd0, bcd_out}, (((cnt / 10) << 4) | (cnt % 10)));
      check("range_now", {30'd0, range_now}, mrange);
      check("overflow", {31'd0, overflow}, (cp > 99) ? 1 : 0);
      last_bcd = bcd_out;
      last_rng = range_now;
      last_ovf = overflow;
      if (!auto_en) mrange = (range_sel > MAXR) ? MAXR : int'(range_sel);
      else if (cp > 99 && mrange < MAXR) mrange = mrange + 1;
      else if (cp <= 99 && cnt < 10 && mrange > 0) mrange = mrange - 1;
    end
  endtask

  // One clock: drive at the falling edge, record the edge, check just after the rising edge.
  task automatic step(input logic sig);
    signal = sig;
    @(posedge clk);
    cyc++;
    if (sig && !prev_sig) ewin[(cyc + 3) / GATE]++;
    prev_sig = sig;
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic set_wave(input int h, input int l);
    hi_t = h;
    lo_t = l;
    ph   = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(ph < hi_t);
      ph = (ph + 1) % (hi_t + lo_t);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    signal  = 1'b0;
    #1;
    check("rst_bcd", {24'd0, bcd_out}, 32'd0);
    check("rst_range", {30'd0, range_now}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    cyc      = 0;
    prev_sig = 1'b0;
    mrange   = 0;
    for (int i = 0; i < 64; i++) ewin[i] = 0;
  endtask

  initial begin
    reset_n   = 1'b0;
    signal    = 1'b0;
    auto_en   = 1'b1;
    range_sel = 2'd0;
    @(negedge clk);
    do_reset();

    // Basic count, period 20
    set_wave(10, 10);
    run(2000);
    check("basic_w2", {24'd0, last_bcd}, 32'h50);

    // Auto up-range, period 4
    set_wave(2, 2);
    run(3000);
    check("up_bcd", {24'd0, last_bcd}, 32'h25);
    check("up_rng", {30'd0, last_rng}, 32'd1);

    // Auto down-range, period 100
    set_wave(50, 50);
    run(2000);
    check("down_bcd", {24'd0, last_bcd}, 32'h10);
    check("down_rng", {30'd0, last_rng}, 32'd0);

    // Manual with clamp, then a mid-window range_sel change
    auto_en   = 1'b0;
    range_sel = 2'd3;
    set_wave(2, 2);
    run(1000);
    run(500);
    range_sel = 2'd1;
    run(500);
    check("clamp_bcd", {24'd0, last_bcd}, 32'h02);
    check("clamp_rng", {30'd0, last_rng}, 32'd2);
    check("clamp_ovf", {31'd0, last_ovf}, 32'd0);
    run(1000);
    check("sel_rng", {30'd0, last_rng}, 32'd1);

    // Randomised periods under auto ranging
    auto_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_wave($urandom_range(2, 30), $urandom_range(2, 30));
      run(1000);
    end

    // Single edge landing on the window-end cycle
    auto_en   = 1'b0;
    range_sel = 2'd0;
    set_wave(0, 1);
    run(1000);
    run(996);
    set_wave(1, 0);
    run(1004);
    check("bnd_next", {24'd0, last_bcd}, 32'h01);

    // Reset in mid-window
    set_wave(0, 1);
    run(500);
    auto_en = 1'b1;
    do_reset();
    set_wave(10, 10);
    run(2000);
    check("rst_after", {24'd0, last_bcd}, 32'h50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_meter_auto.md
Name: freq_meter_auto

Overview:
Parametrised, self-ranging frequency meter. It synchronises an asynchronous input `signal` into the `clk` domain and counts rising edges over a programmable gate window. The count goes into a DIGITS-wide BCD counter behind a decade prescaler. At each window end it latches a display-ready BCD result with range and overflow flags for the LED scanner. It succeeds the fixed 4-digit, 2-range meter with arbitrary digit count, gate length, range depth, automatic range selection and a result-valid strobe.

Parameters:
GATE_CYCLES, 100_000_000, clk cycles per gate window (1 s at 100 MHz); minimum 16
DIGITS, 4, number of BCD digits in the count and result
MAX_RANGE, 3, highest range index r; prescale factor is 10^r; width RW = clog2(MAX_RANGE+1), minimum 1

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
signal  in  1  measured signal, asynchronous to clk
auto_en  in  1  1 = automatic ranging, 0 = manual
range_sel  in  RW  manual range index; values above MAX_RANGE are clamped to MAX_RANGE
bcd_out  out  4*DIGITS  latched count, digit 0 in bits [3:0]
range_now  out  RW  range index in effect for the window reported in bcd_out
overflow  out  1  latched: count saturated in the reported window
valid  out  1  one-cycle pulse when bcd_out/range_now/overflow update

Behaviour:
- Reset (async assert, sync release): bcd_out=0, range_now=0, overflow=0, valid=0, active range=0, gate timer=0, prescaler=0, BCD counter=0, synchroniser flops=0.
- Input path: 2-flop synchroniser, then an edge register. A rising edge produces a 1-cycle edge pulse 3 clk after the input transition.
  - Guaranteed only if `signal` high and low times are each ≥2 clk periods.
- Prescaler: counts edge pulses 0..10^r−1 (r = active range). It emits a count pulse on wrap; for r=0 every edge pulse is a count pulse. Width is sized for 10^MAX_RANGE−1.
- BCD counter:
  - Increments one per count pulse with decimal carry per digit.
  - At all-9s it saturates, holds, and sets an internal sticky ovf bit.
  - No binary-to-BCD conversion anywhere.
- Gate timer: counts 0..GATE_CYCLES−1 and wraps. The terminal cycle (GATE_CYCLES−1) is the window end. At the window end, in that same cycle:
  - Register bcd_out ← counter value before any increment.
  - Register overflow ← ovf, range_now ← active range.
  - Assert valid on the next cycle, for exactly 1 cycle.
  - Clear the prescaler, counter and ovf.
  - Load the next active range.
- Edge pulse coinciding with the window end: it is excluded from the closing window and counted as the first edge of the new window. The prescaler/counter restart as if they had just seen it.
- Next-range decision, made only at a window end:
  - Manual (auto_en=0): min(range_sel, MAX_RANGE).
  - Auto, ovf=1 and r<MAX_RANGE: r+1.
  - Auto, ovf=0, most-significant digit=0 and r>0: r−1.
  - Otherwise r unchanged.
  - No oscillation: a decrement is taken only when the value fits at the lower range.
- Changes to auto_en or range_sel mid-window have no effect until the next window end. The active range never changes mid-window.
- Reported frequency = bcd_out × 10^range_now × (f_clk / GATE_CYCLES).
- Reset mid-window: the partial window is discarded; the first valid after release occurs GATE_CYCLES cycles later.

Test Plan:
- Bench parameters: GATE_CYCLES=1000, DIGITS=2, MAX_RANGE=2, auto_en=1.
- Basic count: signal period 20 clk from reset -> first valid at cycle ~1000, bcd_out=8'h50 (±1 for phase), range_now=0, overflow=0; next window 8'h50.
- Auto up-range: period 4 clk -> window 1: bcd_out=8'h99, overflow=1, range_now=0; window 2: bcd_out=8'h25, overflow=0, range_now=1; window 3 identical.
- Auto down-range: after the previous scenario switch to period 100 clk -> window at r=1 reports 8'h01, range_now=1; next window reports 8'h10, range_now=0.
- Manual clamp: auto_en=0, range_sel=3, period 4 clk -> range_now=2, bcd_out=8'h02 (250/100), overflow=0; range_sel changed mid-window does not change range_now until the following window.
- Boundary edge: align a single edge to the window-end cycle -> closing window excludes it, next window reports it (count 1 with no further edges, bcd_out=8'h01).
- Reset mid-window: assert reset_n=0 at cycle 500 for 3 cycles -> all outputs 0 immediately (asynchronously); next valid exactly 1000 cycles after release; no stale count carried over.
